// File: rtl/counter_pkg.sv
// Shared types and defaults for the PUF measurement-channel counter.
package counter_pkg;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_STEP_W = 4;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } cnt_dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } cnt_mode_e;

endpackage

// File: rtl/counter_step_alu.sv
// Combinational next-count datapath: adds or subtracts the step and
// resolves carry/borrow into either wrap-around or saturation.
module counter_step_alu
    import counter_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STEP_W = DEFAULT_STEP_W
) (
    input  logic [WIDTH-1:0]  cur,
    input  logic [STEP_W-1:0] step,
    input  logic              up,
    input  logic              sat,
    output logic [WIDTH-1:0]  next_out,
    output logic              boundary
);

    logic [WIDTH:0] step_ext;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    cnt_dir_e       dir;
    cnt_mode_e      mode;

    // Zero-extend step to the WIDTH+1 working width.
    generate
        for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_step_ext
            if (gi < STEP_W) begin : g_bit
                assign step_ext[gi] = step[gi];
            end else begin : g_zero
                assign step_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign dir  = cnt_dir_e'(up);
    assign mode = cnt_mode_e'(sat);
    assign sum  = {1'b0, cur} + step_ext;
    assign diff = {1'b0, cur} - step_ext;

    always_comb begin
        next_out = cur;
        boundary = 1'b0;
        if (dir == DIR_UP) begin
            boundary = sum[WIDTH];
            next_out = (boundary && mode == MODE_SAT) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        end else begin
            boundary = diff[WIDTH];
            next_out = (boundary && mode == MODE_SAT) ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/multi_mode_counter.sv
// Up/down wrap/saturate counter with terminal-count pulse and sticky overflow.
// Define MULTI_MODE_COUNTER_CMP_EN to build the registered compare-match output.
module multi_mode_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               STEP_W    = DEFAULT_STEP_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WIDTH-1:0]  in,
    input  logic              enable,
    input  logic              up,
    input  logic              sat,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  cmp_val,
    output logic [WIDTH-1:0]  out,
    output logic              tc,
    output logic              ovf,
    output logic              match
);

    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] out_next;
    logic             tc_reg;
    logic             tc_next;
    logic             ovf_reg;
    logic             ovf_next;
    logic [WIDTH-1:0] alu_next;
    logic             alu_boundary;

    counter_step_alu #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_alu (
        .cur      (out_reg),
        .step     (step),
        .up       (up),
        .sat      (sat),
        .next_out (alu_next),
        .boundary (alu_boundary)
    );

    // Load beats enable; a load also clears the sticky overflow.
    always_comb begin
        out_next = out_reg;
        tc_next  = 1'b0;
        ovf_next = ovf_reg;
        if (load) begin
            out_next = in;
            ovf_next = 1'b0;
        end else if (enable) begin
            out_next = alu_next;
            tc_next  = alu_boundary;
            ovf_next = ovf_reg | alu_boundary;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_reg <= RESET_VAL;
            tc_reg  <= 1'b0;
            ovf_reg <= 1'b0;
        end else begin
            out_reg <= out_next;
            tc_reg  <= tc_next;
            ovf_reg <= ovf_next;
        end
    end

    assign out = out_reg;
    assign tc  = tc_reg;
    assign ovf = ovf_reg;

`ifdef MULTI_MODE_COUNTER_CMP_EN
    logic match_reg;

    // Compare against the value being registered so match lines up with out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_reg <= (RESET_VAL == cmp_val);
        end else begin
            match_reg <= (out_next == cmp_val);
        end
    end

    assign match = match_reg;
`else
    logic unused_cmp_val;
    assign unused_cmp_val = ^cmp_val;
    assign match          = 1'b0;
`endif

endmodule

// File: tb/tb_multi_mode_counter.sv
// Randomized and directed checks of multi_mode_counter against an integer model.
module tb_multi_mode_counter;

`ifdef MULTI_MODE_COUNTER_CMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [7:0] in = 8'h00;
    logic       enable = 1'b0;
    logic       up = 1'b1;
    logic       sat = 1'b0;
    logic [3:0] step = 4'd0;
    logic [7:0] cmp_val = 8'h05;
    logic [7:0] out;
    logic       tc;
    logic       ovf;
    logic       match;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state, plain integers.
    int m_out = 0;
    int m_tc = 0;
    int m_ovf = 0;
    int m_match = 0;

    multi_mode_counter #(
        .WIDTH     (8),
        .STEP_W    (4),
        .RESET_VAL (8'h00)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .in      (in),
        .enable  (enable),
        .up      (up),
        .sat     (sat),
        .step    (step),
        .cmp_val (cmp_val),
        .out     (out),
        .tc      (tc),
        .ovf     (ovf),
        .match   (match)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                     tag, obs, obs, exp, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out"},   int'(out),   m_out);
        check({tag, ".tc"},    int'(tc),    m_tc);
        check({tag, ".ovf"},   int'(ovf),   m_ovf);
        check({tag, ".match"}, int'(match), m_match);
    endtask

    function automatic int cmp_of(input int v);
        return (CMP_EN && v == int'(cmp_val)) ? 1 : 0;
    endfunction

    // Model of one clock edge, from the counting rules using whole numbers.
    task automatic model_edge();
        int v;
        if (load) begin
            m_out = int'(in);
            m_tc  = 0;
            m_ovf = 0;
        end else if (enable) begin
            m_tc = 0;
            if (up) begin
                v = m_out + int'(step);
                if (v > 255) begin
                    m_tc = 1;
                    m_ovf = 1;
                    v = sat ? 255 : v - 256;
                end
            end else begin
                v = m_out - int'(step);
                if (v < 0) begin
                    m_tc = 1;
                    m_ovf = 1;
                    v = sat ? 0 : v + 256;
                end
            end
            m_out = v;
        end else begin
            m_tc = 0;
        end
        m_match = cmp_of(m_out);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        $display("%s t=%0t load=%0b in=%02h en=%0b up=%0b sat=%0b step=%0d cmp=%02h -> out=%02h tc=%0b ovf=%0b match=%0b",
                 tag, $time, load, in, enable, up, sat, step, cmp_val, out, tc, ovf, match);
        check_all(tag);
    endtask

    task automatic drive(input logic l, input logic [7:0] i, input logic e,
                         input logic u, input logic s, input logic [3:0] st);
        load = l; in = i; enable = e; up = u; sat = s; step = st;
    endtask

    // Asserts reset between edges and checks the immediate effect.
    task automatic async_reset(input string tag);
        #2 reset = 1'b0;
        #1;
        m_out = 0; m_tc = 0; m_ovf = 0; m_match = cmp_of(0);
        $display("%s t=%0t async reset -> out=%02h tc=%0b ovf=%0b match=%0b",
                 tag, $time, out, tc, ovf, match);
        check_all(tag);
        #1 reset = 1'b1;
    endtask

    initial begin
        // Reset at time zero, held across an edge.
        #1 reset = 1'b0;
        #1;
        m_match = cmp_of(0);
        $display("reset t=%0t out=%02h tc=%0b ovf=%0b match=%0b", $time, out, tc, ovf, match);
        check_all("reset");
        @(posedge clk);
        #1;
        check_all("reset_hold");
        reset = 1'b1;

        // Up/wrap from FA by 1.
        drive(1, 8'hFA, 0, 1, 0, 4'd1); tick("upwrap_load");
        drive(0, 8'h00, 1, 1, 0, 4'd1);
        for (int i = 0; i < 6; i++) tick("upwrap");
        // Up/saturate from FA by 4.
        drive(1, 8'hFA, 0, 1, 1, 4'd4); tick("upsat_load");
        drive(0, 8'h00, 1, 1, 1, 4'd4);
        for (int i = 0; i < 3; i++) tick("upsat");
        // Down/wrap and down/saturate from 02 by 3.
        drive(1, 8'h02, 0, 0, 0, 4'd3); tick("dnwrap_load");
        drive(0, 8'h00, 1, 0, 0, 4'd3);
        for (int i = 0; i < 2; i++) tick("dnwrap");
        drive(1, 8'h02, 0, 0, 1, 4'd3); tick("dnsat_load");
        drive(0, 8'h00, 1, 0, 1, 4'd3);
        for (int i = 0; i < 2; i++) tick("dnsat");
        // Load wins over enable and clears ovf.
        drive(1, 8'h10, 1, 1, 0, 4'd5); tick("load_prio");
        // Hold and zero step at 0x20.
        drive(1, 8'h1F, 0, 1, 0, 4'd1); tick("hold_load");
        drive(0, 8'h00, 1, 1, 0, 4'd1); tick("hold_count");
        drive(0, 8'h00, 0, 1, 0, 4'd1);
        for (int i = 0; i < 3; i++) tick("hold");
        drive(0, 8'h00, 1, 1, 0, 4'd0);
        for (int i = 0; i < 2; i++) tick("step0");
        // Match while counting up from 0, then reset mid-count at 07.
        cmp_val = 8'h05;
        drive(1, 8'h00, 0, 1, 0, 4'd1); tick("match_load");
        drive(0, 8'h00, 1, 1, 0, 4'd1);
        for (int i = 0; i < 7; i++) tick("match");
        async_reset("areset");
        drive(0, 8'h00, 1, 1, 0, 4'd1); tick("after_reset");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [7:0] r_in;
            r_in = 8'($urandom);
            if ($urandom_range(0, 1) == 0)
                r_in = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(249, 255));
            drive($urandom_range(0, 9) == 0, r_in, $urandom_range(0, 3) != 0,
                  1'($urandom), 1'($urandom), 4'($urandom));
            if ($urandom_range(0, 15) == 0) cmp_val = 8'($urandom);
            if ($urandom_range(0, 3) == 0) cmp_val = 8'(m_out + int'(step));
            tick("rand");
            if ($urandom_range(0, 49) == 0) async_reset("rand_reset");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
